adc_capture_ctrl: RTL and testbench
===================================

# adc_capture_ctrl

Frame-capture sequencer for the dual-channel ADC front end of the spectrum analyzer. Sits between the registered ADC sample outputs (`adc_data`, `adc_data2`) and the FFT sample buffer. On a start command it optionally waits for a level-crossing trigger, then writes `FRAME_LEN` decimated sample pairs into the buffer. It then holds the frame until the FFT side acknowledges it.

## Interface
- `FRAME_LEN`, 1024: samples per frame; power of two.
- `ADDR_W`, 10: buffer address width, equal to log2(`FRAME_LEN`).
- `DATA_W`, 16: ADC sample width.
- `DECIM_W`, 8: decimation field width.

- `adc_dci` in 1: sample clock, rising edge. One new sample pair per cycle.
- `sys_rst` in 1: reset, synchronous, active-high.
- `adc_data` in `DATA_W`: channel A sample, two's complement.
- `adc_data2` in `DATA_W`: channel B sample, two's complement.
- `start` in 1: one-cycle capture request. Honoured only in IDLE.
- `abort` in 1: forces IDLE from any state.
- `cfg_decim` in `DECIM_W`: decimation factor D. Keep one of every D+1 samples.
- `cfg_trig_en` in 1: 1 = wait for trigger; 0 = capture immediately.
- `cfg_trig_ch` in 1: 0 = trigger on channel A, 1 = trigger on channel B.
- `cfg_trig_level` in `DATA_W`: signed trigger threshold.
- `buf_we` out 1: buffer write strobe.
- `buf_addr` out `ADDR_W`: buffer write address.
- `buf_wdata` out 2*`DATA_W`: write data, `{adc_data2, adc_data}`.
- `frame_valid` out 1: a complete frame is in the buffer.
- `frame_ack` in 1: consumer has released the frame.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, ARM, CAPTURE, DONE.
- **Config latch:** all `cfg_*` inputs are latched on the cycle `start` is accepted. Config changes after that have no effect until the next start.
- **IDLE + start:** goes to ARM if `cfg_trig_en`=1, otherwise to CAPTURE.
- **ARM:**
  - Keeps the previous sample of the selected channel and a prev-valid flag. The flag clears when ARM is entered.
  - A trigger is a signed rising crossing: prev < level and current >= level, with prev-valid = 1.
  - The first ARM cycle therefore never triggers.
  - Every input sample is evaluated; decimation does not apply in ARM.
  - There is no trigger timeout. `abort` is the only exit other than a trigger.
- **Anchor cycle k:**
  - Trigger mode: the ARM cycle in which the crossing is detected.
  - Immediate mode: the first CAPTURE cycle.
- **Capture:** capture n (0 ≤ n < `FRAME_LEN`) takes the sample pair present at cycle k+n·(D+1) and writes it to address n.
- **Decimation counter:** loaded with D at each captured sample and decremented each cycle. The next capture happens when it reaches 0. D=0 means every sample.
- **Frame end:** after address `FRAME_LEN`-1 is written, the state goes to DONE. The address does not wrap within a frame and resets to 0 for the next frame.
- **DONE:** `frame_valid`=1, no writes. `frame_ack` moves to IDLE. A `start` in DONE is ignored, including one in the same cycle as `frame_ack`.
- **Ignored inputs:** `frame_ack` outside DONE, and `start` outside IDLE.
- **abort:** in any state, the next state is IDLE. `buf_we`=0 and `frame_valid`=0 from the next cycle. A write already registered for the abort cycle's output is still issued. Partial buffer contents are left as they are.
- **Priority:** `sys_rst` > `abort` > `frame_ack` / trigger / decimation events.

## Timing
- **Reset values:** state IDLE, `buf_we`=0, `buf_addr`=0, `buf_wdata`=0, `frame_valid`=0, `busy`=0. All internal counters and flags are cleared.
- **Write latency:** sample present at cycle c → `buf_we`, `buf_addr`, `buf_wdata` all valid at c+1 (registered outputs).
- **Start:** `start` at cycle t → `busy`=1 at t+1. In immediate mode k = t+1.
- **Trigger mode:** the crossing sample at k is written to address 0 at k+1. The state is CAPTURE from k+1.
- **Last write** is at k+(`FRAME_LEN`-1)(D+1)+1.
- **Frame complete:** `frame_valid`=1 and state DONE from the cycle after the last write.
- **Release:** `frame_ack` at cycle a → `frame_valid`=0 and `busy`=0 at a+1. A new `start` is accepted from a+1.
- **Reset mid-capture:** all outputs take their reset values on the next edge; no further writes.

## Structure
- **Shared package `adc_capture_pkg`:** the state enum type, default values for `FRAME_LEN`, `ADDR_W`, `DATA_W` and `DECIM_W`, and the packing order of `buf_wdata` (channel B in the upper half).
- **Sub-module `adc_trig_detect`:** channel select, previous-sample register, prev-valid flag and signed compare. Output is a one-cycle `trig_hit`.
- The FSM, decimation counter and address counter stay in the top level.

## Test plan
- **Immediate, D=0, FRAME_LEN=1024:** ramp input with `adc_data`=cycle index, `start` at t=10 → 1024 consecutive writes, addresses 0..1023 at cycles 12..1035, `buf_wdata` low half = 11..1034. `frame_valid`=1 at cycle 1036.
- **Decimation D=3:** ramp input, immediate mode → address n holds ramp value (first value)+4n, with writes spaced exactly 4 cycles apart.
- **Trigger, level=0, channel B, sine input:** the first write (address 0) is the first sample ≥0 whose predecessor is <0. Check that a sample already ≥0 on the first ARM cycle does not trigger. Repeat with channel A and level=0x7FFF on a signal that never reaches it → stays in ARM.
- **abort:** pulse `abort` at address 500 → at most one further write, then `busy`=0 and no writes. `start` two cycles later begins a new frame at address 0.
- **DONE handshake:** hold `frame_ack` low for 200 cycles → no writes, `frame_valid` stays 1. `start` and `frame_ack` together → IDLE with no new capture. `start` at the next cycle → capture begins.
- **Reset:** assert `sys_rst` mid-CAPTURE → all outputs at reset values on the next edge. `frame_ack` and `start` asserted during reset are ignored.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC frame-capture sequencer.
package adc_capture_pkg;

    localparam int FRAME_LEN_DEF = 1024;
    localparam int ADDR_W_DEF    = 10;
    localparam int DATA_W_DEF    = 16;
    localparam int DECIM_W_DEF   = 8;

    // Buffer word packing: channel B occupies the upper half of buf_wdata.
    localparam bit WDATA_CH_B_UPPER = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/adc_trig_detect.sv
// Level-crossing trigger: selects a channel, remembers its previous sample
// and flags a signed rising crossing of the threshold.
module adc_trig_detect
    import adc_capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              ch_sel,
    input  logic [DATA_W-1:0] level,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              trig_hit
);

    logic [DATA_W-1:0] cur_sample;
    logic [DATA_W-1:0] prev_sample;
    logic              prev_valid;

    assign cur_sample = ch_sel ? data_b : data_a;

    // Previous-sample history; clr wipes it so the first armed cycle cannot fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample <= '0;
            prev_valid  <= 1'b0;
        end else if (clr) begin
            prev_sample <= '0;
            prev_valid  <= 1'b0;
        end else if (en) begin
            prev_sample <= cur_sample;
            prev_valid  <= 1'b1;
        end
    end

    assign trig_hit = en && prev_valid
                      && ($signed(prev_sample) <  $signed(level))
                      && ($signed(cur_sample)  >= $signed(level));

endmodule

// File: rtl/adc_capture_ctrl.sv
// Frame-capture sequencer between the dual-channel ADC and the FFT buffer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; config is latched when start is taken
// ST_ARM     | watching the selected channel for a rising level crossing
// ST_CAPTURE | writing one decimated sample pair per D+1 cycles
// ST_DONE    | frame complete and held until frame_ack
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DECIM_W   = DECIM_W_DEF
) (
    input  logic                adc_dci,
    input  logic                sys_rst,
    input  logic [DATA_W-1:0]   adc_data,
    input  logic [DATA_W-1:0]   adc_data2,
    input  logic                start,
    input  logic                abort,
    input  logic [DECIM_W-1:0]  cfg_decim,
    input  logic                cfg_trig_en,
    input  logic                cfg_trig_ch,
    input  logic [DATA_W-1:0]   cfg_trig_level,
    output logic                buf_we,
    output logic [ADDR_W-1:0]   buf_addr,
    output logic [2*DATA_W-1:0] buf_wdata,
    output logic                frame_valid,
    input  logic                frame_ack,
    output logic                busy
);

    cap_state_t         state;
    cap_state_t         state_nxt;

    logic [DECIM_W-1:0] decim_q;
    logic               trig_ch_q;
    logic [DATA_W-1:0]  trig_level_q;

    logic [DECIM_W-1:0] dec_cnt;
    logic [ADDR_W-1:0]  addr_cnt;
    logic               frame_full;

    logic               start_ok;
    logic               trig_hit;
    logic               cap_en;
    logic               last_cap;

    assign start_ok = (state == ST_IDLE) && start && !abort;

    // A capture is either the trigger sample itself or a decimation tick;
    // abort suppresses it so nothing new is registered after the abort cycle.
    assign cap_en = !abort
                    && (((state == ST_ARM) && trig_hit)
                        || ((state == ST_CAPTURE) && !frame_full && (dec_cnt == '0)));

    assign last_cap = cap_en && (addr_cnt == ADDR_W'(FRAME_LEN - 1));

    adc_trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig (
        .clk      (adc_dci),
        .rst      (sys_rst),
        .clr      (start_ok),
        .en       (state == ST_ARM),
        .ch_sel   (trig_ch_q),
        .level    (trig_level_q),
        .data_a   (adc_data),
        .data_b   (adc_data2),
        .trig_hit (trig_hit)
    );

    // State register.
    always_ff @(posedge adc_dci) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides every other event.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = cfg_trig_en ? ST_ARM : ST_CAPTURE;
                    end
                end
                ST_ARM: begin
                    if (trig_hit) begin
                        state_nxt = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (frame_full) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (frame_ack) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Config latch, decimation down-counter and write-address counter.
    always_ff @(posedge adc_dci) begin
        if (sys_rst) begin
            decim_q      <= '0;
            trig_ch_q    <= 1'b0;
            trig_level_q <= '0;
            dec_cnt      <= '0;
            addr_cnt     <= '0;
            frame_full   <= 1'b0;
        end else if (start_ok) begin
            decim_q      <= cfg_decim;
            trig_ch_q    <= cfg_trig_ch;
            trig_level_q <= cfg_trig_level;
            dec_cnt      <= '0;
            addr_cnt     <= '0;
            frame_full   <= 1'b0;
        end else if (cap_en) begin
            dec_cnt  <= decim_q;
            addr_cnt <= addr_cnt + 1'b1;
            if (last_cap) begin
                frame_full <= 1'b1;
            end
        end else if ((state == ST_CAPTURE) && (dec_cnt != '0)) begin
            dec_cnt <= dec_cnt - 1'b1;
        end
    end

    // Registered buffer write port.
    always_ff @(posedge adc_dci) begin
        if (sys_rst) begin
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
        end else begin
            buf_we <= cap_en;
            if (cap_en) begin
                buf_addr  <= addr_cnt;
                buf_wdata <= WDATA_CH_B_UPPER ? {adc_data2, adc_data}
                                              : {adc_data, adc_data2};
            end
        end
    end

    assign frame_valid = (state == ST_DONE);
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: immediate, decimated, triggered,
// abort, DONE handshake and reset-during-capture scenarios.
module tb_adc_capture_ctrl;

    localparam int FRAME_LEN = 1024;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 16;
    localparam int DECIM_W   = 8;

    logic                adc_dci;
    logic                sys_rst;
    logic [DATA_W-1:0]   adc_data;
    logic [DATA_W-1:0]   adc_data2;
    logic                start;
    logic                abort;
    logic [DECIM_W-1:0]  cfg_decim;
    logic                cfg_trig_en;
    logic                cfg_trig_ch;
    logic [DATA_W-1:0]   cfg_trig_level;
    logic                buf_we;
    logic [ADDR_W-1:0]   buf_addr;
    logic [2*DATA_W-1:0] buf_wdata;
    logic                frame_valid;
    logic                frame_ack;
    logic                busy;

    int cyc;
    int mode;          // 0 = ramp, 1 = 16-point sine
    int n_checks;
    int n_fail;
    int sin_tab [16];

    adc_capture_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DECIM_W   (DECIM_W)
    ) dut (
        .adc_dci        (adc_dci),
        .sys_rst        (sys_rst),
        .adc_data       (adc_data),
        .adc_data2      (adc_data2),
        .start          (start),
        .abort          (abort),
        .cfg_decim      (cfg_decim),
        .cfg_trig_en    (cfg_trig_en),
        .cfg_trig_ch    (cfg_trig_ch),
        .cfg_trig_level (cfg_trig_level),
        .buf_we         (buf_we),
        .buf_addr       (buf_addr),
        .buf_wdata      (buf_wdata),
        .frame_valid    (frame_valid),
        .frame_ack      (frame_ack),
        .busy           (busy)
    );

    initial begin
        adc_dci = 1'b0;
        forever #5 adc_dci = ~adc_dci;
    end

    function automatic logic [15:0] wave_a(input int c);
        int v;
        if (mode == 0) v = c;
        else           v = sin_tab[(c + 4) % 16] / 2;
        return v[15:0];
    endfunction

    function automatic logic [15:0] wave_b(input int c);
        int v;
        if (mode == 0) v = c ^ 32'h0000A5A5;
        else           v = sin_tab[c % 16];
        return v[15:0];
    endfunction

    function automatic logic [31:0] exp_word(input int c);
        return {wave_b(c), wave_a(c)};
    endfunction

    task automatic drive();
        adc_data  = wave_a(cyc);
        adc_data2 = wave_b(cyc);
    endtask

    task automatic tick();
        @(posedge adc_dci);
        #1;
        cyc++;
        drive();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int t;
        int bad;
        int extra;
        int found;

        sin_tab = '{0, 12539, 23170, 30273, 32767, 30273, 23170, 12539,
                    0, -12539, -23170, -30273, -32767, -30273, -23170, -12539};
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        mode     = 0;
        sys_rst  = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        frame_ack      = 1'b0;
        cfg_decim      = '0;
        cfg_trig_en    = 1'b0;
        cfg_trig_ch    = 1'b0;
        cfg_trig_level = '0;
        drive();
        repeat (3) tick();
        sys_rst = 1'b0;
        tick();

        // Reset state
        chk("rst_we",    buf_we, 0);
        chk("rst_addr",  buf_addr, 0);
        chk("rst_wdata", buf_wdata, 0);
        chk("rst_fv",    frame_valid, 0);
        chk("rst_busy",  busy, 0);

        // Immediate capture, D=0, config changed after start must not matter
        repeat (5) tick();
        t = cyc;
        cfg_decim = 8'd0;
        cfg_trig_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_decim = 8'd5;
        cfg_trig_en = 1'b1;
        chk("imm_busy", busy, 1);
        chk("imm_no_early_we", buf_we, 0);
        tick();
        chk("imm_first_we",   buf_we, 1);
        chk("imm_first_addr", buf_addr, 0);
        chk("imm_first_data", buf_wdata, exp_word(t + 1));
        bad = 0;
        for (int n = 0; n < FRAME_LEN; n++) begin
            if (buf_we !== 1'b1 || buf_addr !== ADDR_W'(n) || buf_wdata !== exp_word(t + 1 + n))
                bad++;
            // stray start / frame_ack mid-capture must be ignored
            start     = (n == 100);
            frame_ack = (n == 100);
            if (n < FRAME_LEN - 1) tick();
        end
        start = 1'b0;
        frame_ack = 1'b0;
        chk("imm_writes_bad", bad, 0);
        chk("imm_last_cycle", cyc, t + 1025);
        chk("imm_last_addr",  buf_addr, 1023);
        chk("imm_fv_at_last", frame_valid, 0);
        tick();
        chk("imm_done_fv",   frame_valid, 1);
        chk("imm_done_we",   buf_we, 0);
        chk("imm_done_busy", busy, 1);

        // DONE hold for 200 cycles, a lone start in there is ignored
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            start = (i == 50);
            tick();
            if (buf_we !== 1'b0 || frame_valid !== 1'b1 || busy !== 1'b1) bad++;
        end
        start = 1'b0;
        chk("done_hold_bad", bad, 0);

        // start together with frame_ack: release only, no new capture
        cfg_decim = 8'd3;
        cfg_trig_en = 1'b0;
        start = 1'b1;
        frame_ack = 1'b1;
        tick();
        start = 1'b0;
        frame_ack = 1'b0;
        chk("ack_fv",   frame_valid, 0);
        chk("ack_busy", busy, 0);

        // Decimated frame D=3 started on the cycle right after release
        t = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("d3_busy", busy, 1);
        tick();
        bad = 0;
        for (int j = 0; j <= 4092; j++) begin
            if (j % 4 == 0) begin
                if (buf_we !== 1'b1 || buf_addr !== ADDR_W'(j / 4) || buf_wdata !== exp_word(t + 1 + j))
                    bad++;
            end else if (buf_we !== 1'b0) begin
                bad++;
            end
            if (j < 4092) tick();
        end
        chk("d3_writes_bad", bad, 0);
        chk("d3_last_addr",  buf_addr, 1023);
        chk("d3_fv_at_last", frame_valid, 0);
        tick();
        chk("d3_done_fv", frame_valid, 1);
        chk("d3_done_we", buf_we, 0);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("d3_ack_busy", busy, 0);

        // Abort at address 500, then a fresh frame two cycles later
        cfg_decim = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            tick();
            if (buf_we === 1'b1 && buf_addr === 10'd500) found = 1;
        end
        chk("abort_reach500", found, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        extra = int'(buf_we);
        chk("abort_we_next",   buf_we, 0);
        chk("abort_busy_next", busy, 0);
        chk("abort_fv_next",   frame_valid, 0);
        tick();
        extra += int'(buf_we);
        chk("abort_extra_le1", (extra <= 1), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", busy, 1);
        tick();
        chk("restart_we",   buf_we, 1);
        chk("restart_addr", buf_addr, 0);
        chk("restart_data", buf_wdata, exp_word(cyc - 1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("restart_abort_busy", busy, 0);

        // Trigger on channel B, level 0, sine; first ARM sample is 0 (>=0)
        mode = 1;
        drive();
        cfg_trig_en = 1'b1;
        cfg_trig_ch = 1'b1;
        cfg_trig_level = 16'h0000;
        found = 0;
        for (int i = 0; i < 16 && found == 0; i++) begin
            if (cyc % 16 == 15) found = 1;
            else tick();
        end
        t = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("trgb_busy", busy, 1);
        chk("trgb_first_arm_we", buf_we, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (buf_we !== 1'b0 || busy !== 1'b1) bad++;
        end
        chk("trgb_no_early_trigger", bad, 0);
        tick();
        chk("trgb_first_we",   buf_we, 1);
        chk("trgb_first_addr", buf_addr, 0);
        chk("trgb_first_data", buf_wdata, exp_word(t + 17));
        tick();
        chk("trgb_second_addr", buf_addr, 1);
        chk("trgb_second_data", buf_wdata, exp_word(t + 18));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("trgb_abort_busy", busy, 0);

        // Trigger on channel A at 0x7FFF: never reached, stays armed
        cfg_trig_ch = 1'b0;
        cfg_trig_level = 16'h7FFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_trig_ch = 1'b1;
        cfg_trig_level = 16'h0000;
        cfg_trig_en = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (buf_we !== 1'b0 || busy !== 1'b1 || frame_valid !== 1'b0) bad++;
        end
        chk("trga_stays_armed", bad, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("trga_abort_busy", busy, 0);

        // Reset in the middle of a capture
        mode = 0;
        drive();
        cfg_decim = 8'd0;
        cfg_trig_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("rstcap_pre_we", buf_we, 1);
        sys_rst = 1'b1;
        frame_ack = 1'b1;
        start = 1'b1;
        tick();
        chk("rstcap_we",    buf_we, 0);
        chk("rstcap_addr",  buf_addr, 0);
        chk("rstcap_wdata", buf_wdata, 0);
        chk("rstcap_fv",    frame_valid, 0);
        chk("rstcap_busy",  busy, 0);
        repeat (2) tick();
        sys_rst = 1'b0;
        frame_ack = 1'b0;
        start = 1'b0;
        bad = 0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0 || buf_we !== 1'b0) bad++;
        end
        chk("rstcap_idle_after", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
